// File: rtl/rs544522_lane_packer_if.sv
// Symbol-in / beat-out stream bundle for rs544522_lane_packer.
// The slave modport is the packer; the master modport is the source and sink around it.
interface rs544522_lane_packer_if #(
  parameter int W = 10,
  parameter int L = 7
);
  logic         in_valid_i;
  logic         in_ready_o;
  logic         in_sop_i;
  logic         in_eop_i;
  logic [W-1:0] in_sym_i;
  logic         start_o;
  logic         valid_o;
  logic         last_o;
  logic [W-1:0] s_blk_o [0:L-1];

  modport slave (
    input  in_valid_i,
    input  in_sop_i,
    input  in_eop_i,
    input  in_sym_i,
    output in_ready_o,
    output start_o,
    output valid_o,
    output last_o,
    output s_blk_o
  );

  modport master (
    output in_valid_i,
    output in_sop_i,
    output in_eop_i,
    output in_sym_i,
    input  in_ready_o,
    input  start_o,
    input  valid_o,
    input  last_o,
    input  s_blk_o
  );
endinterface

// File: rtl/rs544522_lane_packer.sv
// Frames a symbol stream into zero-padded, MSB-first 7-lane beats for the RS(544,522) encoder.
// Define RS_PACK_ERRCNT_EN to add the saturating 16-bit err_cnt_o framing-error counter.
module rs544522_lane_packer #(
  parameter int W = 10,
  parameter int K = 522,
  parameter int L = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  rs544522_lane_packer_if.slave bus,
`ifdef RS_PACK_ERRCNT_EN
  output logic [15:0]           err_cnt_o,
`endif
  output logic                  err_o
);

  localparam int NBEAT = (K + L - 1) / L;
  localparam int PAD   = NBEAT * L - K;
  localparam int LW    = 3;
  localparam int BW    = 7;
  localparam int CW    = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FLUSH,
    ST_SKIP
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   buf_q [L];
  logic [W-1:0]   buf_d [L];
  logic [W-1:0]   blk_q [L];
  logic [W-1:0]   blk_d [L];
  logic [LW-1:0]  lane_q, lane_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           start_q, start_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic           err_q, err_d;

  // Write-path temporaries: which lane/beat/index the accepted symbol lands on.
  logic           accept;
  logic           in_ready;
  logic           wr_en;
  logic [LW-1:0]  wr_lane;
  logic [BW-1:0]  wr_beat;
  logic [CW-1:0]  wr_idx;
  logic [W-1:0]   wbuf [L];
  logic           frame_end;
  logic           early;
  logic           emit;

  assign in_ready = (state_q != ST_FLUSH);
  assign accept   = bus.in_valid_i && in_ready;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    blk_d   = blk_q;
    lane_d  = lane_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_lane = lane_q;
    wr_beat = beat_q;
    wr_idx  = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.in_sop_i) begin
            wr_en   = 1'b1;
            wr_lane = LW'(PAD);
            wr_beat = '0;
            wr_idx  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (bus.in_sop_i) err_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        valid_d = 1'b1;
        start_d = (beat_q == '0);
        last_d  = (beat_q == BW'(NBEAT - 1));
        for (int i = 0; i < L; i++) blk_d[i] = '0;
        if (last_d) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      ST_SKIP: begin
        if (accept && bus.in_eop_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new frame starts from an all-zero buffer so the pad lanes are zero.
    for (int i = 0; i < L; i++) begin
      wbuf[i] = (state_q == ST_IDLE) ? '0 : buf_q[i];
      if (wr_lane == LW'(i)) wbuf[i] = bus.in_sym_i;
    end
    frame_end = (wr_idx == CW'(K - 1));
    early     = bus.in_eop_i && !frame_end;
    emit      = (wr_lane == LW'(L - 1)) || early;

    if (wr_en) begin
      state_d = ST_FILL;
      cnt_d   = wr_idx + CW'(1);
      if (emit) begin
        valid_d = 1'b1;
        start_d = (wr_beat == '0);
        last_d  = (wr_beat == BW'(NBEAT - 1));
        blk_d   = wbuf;
        for (int i = 0; i < L; i++) buf_d[i] = '0;
        lane_d  = '0;
        beat_d  = wr_beat + BW'(1);
      end else begin
        buf_d  = wbuf;
        lane_d = wr_lane + LW'(1);
        beat_d = wr_beat;
      end
      if (frame_end) begin
        // Symbol K-1 always closes the last beat; a missing eop parks us in SKIP.
        beat_d  = '0;
        cnt_d   = '0;
        state_d = bus.in_eop_i ? ST_IDLE : ST_SKIP;
        if (!bus.in_eop_i) err_d = 1'b1;
      end else if (early) begin
        err_d = 1'b1;
        if (wr_beat == BW'(NBEAT - 1)) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end else begin
          state_d = ST_FLUSH;
        end
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < L; i++) begin
        buf_q[i] <= '0;
        blk_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
      for (int i = 0; i < L; i++) begin
        buf_q[i] <= buf_d[i];
        blk_q[i] <= blk_d[i];
      end
    end
  end

`ifdef RS_PACK_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_cnt_q <= '0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

  assign bus.in_ready_o = in_ready;
  assign bus.start_o    = start_q;
  assign bus.valid_o    = valid_q;
  assign bus.last_o     = last_q;
  assign err_o          = err_q;

  for (genvar gi = 0; gi < L; gi++) begin : g_lane
    assign bus.s_blk_o[gi] = blk_q[gi];
  end

endmodule

// File: tb/tb_rs544522_lane_packer.sv
// Self-checking bench for rs544522_lane_packer: frame-level reference model plus per-cycle compare.
// Covers normal, back-to-back, gapped, early-eop, missing-eop, sop-less and mid-frame reset cases.
module tb_rs544522_lane_packer;
  localparam int W      = 10;
  localparam int K      = 522;
  localparam int L      = 7;
  localparam int NBEAT  = (K + L - 1) / L;
  localparam int PAD    = NBEAT * L - K;
  localparam int DW     = L * W;
  localparam int MAXSYM = 640;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          start;
    logic          last;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic err;

  rs544522_lane_packer_if #(.W(W), .L(L)) bus ();
`ifdef RS_PACK_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  rs544522_lane_packer #(.W(W), .K(K), .L(L)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .bus       (bus),
`ifdef RS_PACK_ERRCNT_EN
    .err_cnt_o (err_cnt),
`endif
    .err_o     (err)
  );

  always #5 clk = ~clk;

  int            n_tests     = 0;
  int            n_fail      = 0;
  int            exp_err     = 0;
  int            seen_err    = 0;
  int            exp_err_cnt = 0;
  beat_t         exp_q [$];
  logic [W-1:0]  frame_syms [MAXSYM];
  logic [DW-1:0] model_beats [NBEAT];

  function automatic void check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endfunction

  function automatic logic [DW-1:0] pack7(input int a, input int b, input int c, input int d,
                                          input int e, input int f, input int g);
    int            v [7];
    logic [DW-1:0] r;
    v = '{a, b, c, d, e, f, g};
    r = '0;
    for (int l = 0; l < 7; l++) r[(L-1-l)*W +: W] = W'(v[l]);
    return r;
  endfunction

  function automatic logic [DW-1:0] dut_blk();
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < L; l++) r[(L-1-l)*W +: W] = bus.s_blk_o[l];
    return r;
  endfunction

  // Reference: lay the message out on the padded stream, then cut it into L-wide beats.
  function automatic void model_build(input int n_data);
    logic [W-1:0] stream [NBEAT*L];
    for (int p = 0; p < NBEAT*L; p++) stream[p] = '0;
    for (int i = 0; i < n_data && i < K; i++) stream[PAD+i] = frame_syms[i];
    for (int b = 0; b < NBEAT; b++) begin
      model_beats[b] = '0;
      for (int l = 0; l < L; l++) model_beats[b][(L-1-l)*W +: W] = stream[b*L+l];
    end
  endfunction

  // Compare process: every output beat is checked against the model queue.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (bus.valid_o) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_beat: got beat %0h, expected no beat", dut_blk());
        end else begin
          e = exp_q.pop_front();
          check("beat_data", dut_blk(), e.data);
          check("beat_start", DW'(bus.start_o), DW'(e.start));
          check("beat_last", DW'(bus.last_o), DW'(e.last));
        end
      end else begin
        check("idle_flags", DW'({bus.start_o, bus.last_o}), DW'(0));
      end
      if (err) seen_err++;
    end
  end

  task automatic send(input logic [W-1:0] sym, input logic sop, input logic eop, input int gap);
    int guard;
    while ($urandom_range(0, 99) < gap) begin
      bus.in_valid_i = 1'b0;
      @(negedge clk);
    end
    bus.in_valid_i = 1'b1;
    bus.in_sym_i   = sym;
    bus.in_sop_i   = sop;
    bus.in_eop_i   = eop;
    guard = 0;
    while (!bus.in_ready_o) begin
      @(negedge clk);
      guard++;
      if (guard > 1000) begin
        n_tests++;
        n_fail++;
        $display("FAIL ready_timeout: got in_ready_o=0 for %0d cycles, expected 1", guard);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "ready timeout");
      end
    end
    @(negedge clk);
  endtask

  // Drive one frame; n_stop < n_sym abandons it early (used for the reset case).
  task automatic drive_frame(input int n_sym, input int eop_idx, input int gap, input int n_stop);
    bit    complete;
    int    n_data;
    int    nb;
    int    r;
    beat_t bt;
    complete = (n_stop >= n_sym);
    n_data   = complete ? ((eop_idx + 1 < K) ? eop_idx + 1 : K) : ((n_stop < K) ? n_stop : K);
    nb       = complete ? NBEAT : (PAD + n_stop) / L;
    model_build(n_data);
    for (int b = 0; b < nb; b++) begin
      bt.data  = model_beats[b];
      bt.start = (b == 0);
      bt.last  = (b == NBEAT - 1);
      exp_q.push_back(bt);
    end
    if (complete && eop_idx != K - 1) begin
      exp_err++;
      exp_err_cnt++;
    end
    for (int i = 0; i < n_stop; i++) begin
      send(frame_syms[i], i == 0, i == eop_idx, gap);
      if (i < K && (((PAD + i) % L == L - 1) || i == eop_idx))
        check("beat_latency", DW'(bus.valid_o), DW'(1));
      if (i == eop_idx) begin
        bus.in_valid_i = 1'b0;
        if (i < K - 1) begin
          r = NBEAT - 1 - (PAD + i) / L;
          for (int k = 0; k <= r; k++) begin
            if (k > 0) begin
              @(negedge clk);
              check("flush_valid", DW'(bus.valid_o), DW'(1));
            end
            if (k < r) check("flush_ready", DW'(bus.in_ready_o), DW'(0));
          end
        end
        break;
      end
    end
    bus.in_valid_i = 1'b0;
  endtask

  task automatic fill_count(input int n);
    for (int i = 0; i < n; i++) frame_syms[i] = W'(i + 1);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) frame_syms[i] = W'($urandom_range(0, 1023));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish within time limit, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    int n;
    int eop;
    int guard;
    bus.in_valid_i = 1'b0;
    bus.in_sop_i   = 1'b0;
    bus.in_eop_i   = 1'b0;
    bus.in_sym_i   = '0;

    repeat (3) @(negedge clk);
    check("reset_ready", DW'(bus.in_ready_o), DW'(1));
    check("reset_valid", DW'({bus.valid_o, bus.start_o, bus.last_o, err}), DW'(0));
    check("reset_blk", dut_blk(), DW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Frame 1..522: pin the model's first and last beat by hand.
    fill_count(K);
    model_build(K);
    check("pin_beat0", model_beats[0], pack7(0, 0, 0, 1, 2, 3, 4));
    check("pin_beat74", model_beats[NBEAT-1], pack7(516, 517, 518, 519, 520, 521, 522));
    drive_frame(K, K - 1, 0, K);

    // Two back-to-back random frames.
    fill_random(K);
    drive_frame(K, K - 1, 0, K);
    fill_random(K);
    drive_frame(K, K - 1, 0, K);

    // Gapped input.
    fill_count(K);
    drive_frame(K, K - 1, 30, K);

    // Early eop on symbol 100: value v sits at stream position v+2, so beat 14 holds 96..100.
    fill_count(K);
    model_build(100);
    check("pin_flush_beat14", model_beats[14], pack7(96, 97, 98, 99, 100, 0, 0));
    check("pin_flush_beat15", model_beats[15], DW'(0));
    drive_frame(K, 99, 0, K);

    // Missing eop: 530 symbols, then an immediate normal frame.
    fill_count(530);
    model_build(530);
    check("pin_missing_beat74", model_beats[NBEAT-1], pack7(516, 517, 518, 519, 520, 521, 522));
    drive_frame(530, 529, 0, 530);
    fill_random(K);
    drive_frame(K, K - 1, 20, K);

    // Symbol without sop in IDLE is dropped with an error.
    send(W'(5), 1'b0, 1'b0, 0);
    bus.in_valid_i = 1'b0;
    check("drop_err", DW'(err), DW'(1));
    exp_err++;
    exp_err_cnt++;
    @(negedge clk);

`ifdef RS_PACK_ERRCNT_EN
    check("err_cnt_before_reset", DW'(err_cnt), DW'(exp_err_cnt));
`endif

    // Reset mid-frame after 199 symbols, then a clean frame.
    fill_count(K);
    drive_frame(K, K - 1, 0, 199);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", DW'({bus.valid_o, bus.start_o, bus.last_o, err}), DW'(0));
    check("rst_mid_ready", DW'(bus.in_ready_o), DW'(1));
    check("rst_mid_blk", dut_blk(), DW'(0));
    check("rst_mid_stale", DW'(exp_q.size()), DW'(0));
    exp_err_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_count(K);
    drive_frame(K, K - 1, 0, K);

    // Randomised frames: normal, early eop anywhere, or overlong.
    for (int f = 0; f < 5; f++) begin
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        n = K;
        eop = K - 1;
      end else if (mode == 1) begin
        eop = $urandom_range(0, K - 2);
        n = eop + 1;
      end else begin
        n = $urandom_range(K + 1, K + 12);
        eop = n - 1;
      end
      fill_random(n);
      drive_frame(n, eop, $urandom_range(0, 40), n);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check("drain_empty", DW'(exp_q.size()), DW'(0));
    check("err_pulses", DW'(seen_err), DW'(exp_err));
`ifdef RS_PACK_ERRCNT_EN
    check("err_cnt_final", DW'(err_cnt), DW'(exp_err_cnt));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
